// File: rtl/core_pkg.sv
// ============================================================================
// Module      : core_pkg
// Description : Shared latency constants and index types for the DP-stage
//               hazard scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package core_pkg;

  localparam int LAT_W    = 3;
  localparam int LAT_ALU  = 0;
  localparam int LAT_LOAD = 1;
  localparam int LAT_FADD = 2;
  localparam int LAT_FMUL = 2;
  localparam int LAT_FDIV = 5;

  typedef logic [LAT_W-1:0] lat_t;
  typedef logic [4:0]       reg_idx_t;

endpackage : core_pkg

`default_nettype wire

// File: rtl/sb_file.sv
// ============================================================================
// Module      : sb_file
// Description : One register file's bank of in-flight countdown timers, with
//               load port, auto-decrement, indexed read ports and match-any.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sb_file #(
  parameter int NREG     = 32,
  parameter int LAT_W    = 3,
  parameter int NRD      = 3,
  parameter bit TIE_ZERO = 1'b0
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          load_en,
  input  core_pkg::reg_idx_t            load_idx,
  input  logic [LAT_W-1:0]              load_val,
  input  logic [NRD-1:0][4:0]           rd_idx,
  output logic [NRD-1:0][LAT_W-1:0]     rd_cnt,
  input  logic [LAT_W:0]                match_val,
  output logic                          match_any,
  output logic [NREG-1:0]               busy
);

  import core_pkg::*;

  logic [LAT_W-1:0] r_cnt [NREG];

  for (genvar g = 0; g < NREG; g++) begin : g_entry
    if (TIE_ZERO && g == 0) begin : g_tied
      assign r_cnt[g] = '0;
    end else begin : g_live
      // A load wins over the same-cycle decrement.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          r_cnt[g] <= '0;
        end else if (load_en && load_idx == reg_idx_t'(g)) begin
          r_cnt[g] <= load_val;
        end else if (r_cnt[g] != '0) begin
          r_cnt[g] <= r_cnt[g] - LAT_W'(1);
        end
      end
    end
    assign busy[g] = (r_cnt[g] != '0);
  end

  always_comb begin
    for (int j = 0; j < NRD; j++) begin
      rd_cnt[j] = r_cnt[rd_idx[j]];
    end
  end

  always_comb begin
    match_any = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      if ({1'b0, r_cnt[i]} == match_val) match_any = 1'b1;
    end
  end

endmodule : sb_file

`default_nettype wire

// File: rtl/hazard_scoreboard.sv
// ============================================================================
// Module      : hazard_scoreboard
// Description : DP-stage issue-hazard unit: RAW, result-bus and WAW stalls
//               from per-register countdown timers (int and fp files).
//               Optional macro HAZARD_PERF_CNT_EN adds stall cycle counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_scoreboard #(
  parameter int LAT_W = 3,
  parameter int NREG  = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  core_pkg::reg_idx_t   rs1_dp,
  input  core_pkg::reg_idx_t   rs2_dp,
  input  core_pkg::reg_idx_t   rs3_dp,
  input  logic [2:0]           rs_fpu_dp,
  input  logic [2:0]           rs_use_dp,
  input  core_pkg::reg_idx_t   rd_dp,
  input  logic                 rd_fpu_dp,
  input  logic                 reg_write_dp,
  input  logic                 valid_dp,
  input  logic [LAT_W-1:0]     lat_dp,
  input  logic                 flush_dp,
  output logic                 stall_dp,
  output logic                 issue_dp,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0]          stall_cycles,
  output logic [31:0]          stall_raw_cycles,
`endif
  output logic [NREG-1:0]      busy_int,
  output logic [NREG-1:0]      busy_fp
);

  import core_pkg::*;

  localparam int c_NRD = 4;  // rs1, rs2, rs3, rd

  logic [c_NRD-1:0][4:0]       w_rd_idx;
  logic [c_NRD-1:0][LAT_W-1:0] w_int_cnt;
  logic [c_NRD-1:0][LAT_W-1:0] w_fp_cnt;
  logic [LAT_W:0]              w_lat_p1;
  logic                        w_int_match;
  logic                        w_fp_match;
  logic                        w_load;
  logic [2:0]                  w_src_busy;
  logic [LAT_W-1:0]            w_dst_cnt;
  logic                        w_raw;
  logic                        w_bus;
  logic                        w_waw;

  assign w_rd_idx = {rd_dp, rs3_dp, rs2_dp, rs1_dp};
  assign w_lat_p1 = {1'b0, lat_dp} + (LAT_W+1)'(1);
  assign w_load   = issue_dp & reg_write_dp;

  sb_file #(.NREG(NREG), .LAT_W(LAT_W), .NRD(c_NRD), .TIE_ZERO(1'b1)) u_int (
    .clk       (clk),
    .rstn      (rstn),
    .load_en   (w_load & ~rd_fpu_dp),
    .load_idx  (rd_dp),
    .load_val  (lat_dp),
    .rd_idx    (w_rd_idx),
    .rd_cnt    (w_int_cnt),
    .match_val (w_lat_p1),
    .match_any (w_int_match),
    .busy      (busy_int)
  );

  sb_file #(.NREG(NREG), .LAT_W(LAT_W), .NRD(c_NRD), .TIE_ZERO(1'b0)) u_fp (
    .clk       (clk),
    .rstn      (rstn),
    .load_en   (w_load & rd_fpu_dp),
    .load_idx  (rd_dp),
    .load_val  (lat_dp),
    .rd_idx    (w_rd_idx),
    .rd_cnt    (w_fp_cnt),
    .match_val (w_lat_p1),
    .match_any (w_fp_match),
    .busy      (busy_fp)
  );

  // Source bit order in rs_fpu_dp/rs_use_dp is [2]=rs1, [1]=rs2, [0]=rs3.
  always_comb begin
    w_src_busy = '0;
    for (int i = 0; i < 3; i++) begin
      w_src_busy[2-i] = rs_use_dp[2-i] &
        ((rs_fpu_dp[2-i] ? w_fp_cnt[i] : w_int_cnt[i]) != '0);
    end
  end

  assign w_dst_cnt = rd_fpu_dp ? w_fp_cnt[3] : w_int_cnt[3];
  assign w_raw     = |w_src_busy;
  assign w_bus     = reg_write_dp & (w_int_match | w_fp_match);
  assign w_waw     = reg_write_dp & ({1'b0, w_dst_cnt} >= w_lat_p1);

  assign stall_dp = rstn & valid_dp & ~flush_dp & (w_raw | w_bus | w_waw);
  assign issue_dp = rstn & valid_dp & ~flush_dp & ~stall_dp;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_stall_raw_cycles;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stall_cycles     <= '0;
      r_stall_raw_cycles <= '0;
    end else begin
      if (stall_dp) r_stall_cycles <= r_stall_cycles + 32'd1;
      if (stall_dp & w_raw & ~w_bus & ~w_waw) r_stall_raw_cycles <= r_stall_raw_cycles + 32'd1;
    end
  end

  assign stall_cycles     = r_stall_cycles;
  assign stall_raw_cycles = r_stall_raw_cycles;
`endif

`ifndef SYNTHESIS
  a_lat_legal: assert property (@(posedge clk) disable iff (!rstn)
    (valid_dp && !flush_dp && reg_write_dp) |-> (lat_dp != '1));
`endif

endmodule : hazard_scoreboard

`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
// ============================================================================
// Module      : tb_hazard_scoreboard
// Description : Directed scoreboard bench for hazard_scoreboard; build with
//               HAZARD_PERF_CNT_EN to also check the stall counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_scoreboard;

  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  reg_idx_t    rs1_dp, rs2_dp, rs3_dp, rd_dp;
  logic [2:0]  rs_fpu_dp, rs_use_dp;
  logic        rd_fpu_dp, reg_write_dp, valid_dp, flush_dp;
  logic [2:0]  lat_dp;
  logic        stall_dp, issue_dp;
  logic [31:0] busy_int, busy_fp;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, stall_raw_cycles;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       nm;
    logic        es;
    logic        ei;
    logic [31:0] bfp;
    logic [31:0] bint;
    logic        cp;
    int          sc;
    int          src;
  } exp_t;

  exp_t q[$];

  hazard_scoreboard #(.LAT_W(3), .NREG(32)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .rs1_dp       (rs1_dp),
    .rs2_dp       (rs2_dp),
    .rs3_dp       (rs3_dp),
    .rs_fpu_dp    (rs_fpu_dp),
    .rs_use_dp    (rs_use_dp),
    .rd_dp        (rd_dp),
    .rd_fpu_dp    (rd_fpu_dp),
    .reg_write_dp (reg_write_dp),
    .valid_dp     (valid_dp),
    .lat_dp       (lat_dp),
    .flush_dp     (flush_dp),
    .stall_dp     (stall_dp),
    .issue_dp     (issue_dp),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cycles     (stall_cycles),
    .stall_raw_cycles (stall_raw_cycles),
`endif
    .busy_int     (busy_int),
    .busy_fp      (busy_fp)
  );

  always #5 clk = ~clk;

  // Monitor: pops one expectation per presented cycle, mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      checks++;
      if (stall_dp !== e.es) begin
        errors++;
        $display("FAIL %s stall_dp got %0b want %0b", e.nm, stall_dp, e.es);
      end
      checks++;
      if (issue_dp !== e.ei) begin
        errors++;
        $display("FAIL %s issue_dp got %0b want %0b", e.nm, issue_dp, e.ei);
      end
      checks++;
      if (busy_fp !== e.bfp) begin
        errors++;
        $display("FAIL %s busy_fp got %h want %h", e.nm, busy_fp, e.bfp);
      end
      checks++;
      if (busy_int !== e.bint) begin
        errors++;
        $display("FAIL %s busy_int got %h want %h", e.nm, busy_int, e.bint);
      end
`ifdef HAZARD_PERF_CNT_EN
      if (e.cp) begin
        checks++;
        if (stall_cycles !== 32'(e.sc)) begin
          errors++;
          $display("FAIL %s stall_cycles got %0d want %0d", e.nm, stall_cycles, e.sc);
        end
        checks++;
        if (stall_raw_cycles !== 32'(e.src)) begin
          errors++;
          $display("FAIL %s stall_raw_cycles got %0d want %0d", e.nm, stall_raw_cycles, e.src);
        end
      end
`endif
    end
  end

  task automatic drive(input logic v, input reg_idx_t r1, input logic [2:0] fpu,
                       input logic [2:0] usem, input reg_idx_t rd, input logic rdf,
                       input logic wr, input logic [2:0] lat, input logic fl);
    valid_dp = v; rs1_dp = r1; rs2_dp = 5'd0; rs3_dp = 5'd0;
    rs_fpu_dp = fpu; rs_use_dp = usem; rd_dp = rd; rd_fpu_dp = rdf;
    reg_write_dp = wr; lat_dp = lat; flush_dp = fl;
  endtask

  task automatic expect_now(input string nm, input logic es, input logic ei,
                            input logic [31:0] bfp, input logic [31:0] bint,
                            input logic cp, input int sc, input int src);
    exp_t e;
    e.nm = nm; e.es = es; e.ei = ei; e.bfp = bfp; e.bint = bint;
    e.cp = cp; e.sc = sc; e.src = src;
    q.push_back(e);
  endtask

  // One cycle: drive inputs, queue the expectation, advance past the edge.
  task automatic cyc(input string nm, input logic v, input reg_idx_t r1,
                     input logic [2:0] fpu, input logic [2:0] usem, input reg_idx_t rd,
                     input logic rdf, input logic wr, input logic [2:0] lat, input logic fl,
                     input logic es, input logic ei, input logic [31:0] bfp,
                     input logic [31:0] bint);
    drive(v, r1, fpu, usem, rd, rdf, wr, lat, fl);
    expect_now(nm, es, ei, bfp, bint, 1'b0, 0, 0);
    @(posedge clk); #1;
  endtask

  task automatic idle(input string nm, input logic [31:0] bfp, input logic [31:0] bint);
    cyc(nm, 1'b0, 5'd0, 3'b000, 3'b000, 5'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, bfp, bint);
  endtask

  initial begin
    rstn = 1'b0;
    drive(1'b0, 5'd0, 3'b000, 3'b000, 5'd0, 1'b0, 1'b0, 3'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    expect_now("reset_state", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 0, 0);
    @(posedge clk); #1;

    // RAW: fmul f3 then fadd f6 <- f3
    cyc("raw_fmul",   1, 5'd3, 3'b000, 3'b000, 5'd3, 1, 1, 3'(LAT_FMUL), 0, 0, 1, 32'h0, 32'h0);
    cyc("raw_stall1", 1, 5'd3, 3'b100, 3'b100, 5'd6, 1, 1, 3'(LAT_FADD), 0, 1, 0, 32'h8, 32'h0);
    cyc("raw_stall2", 1, 5'd3, 3'b100, 3'b100, 5'd6, 1, 1, 3'(LAT_FADD), 0, 1, 0, 32'h8, 32'h0);
    cyc("raw_issue",  1, 5'd3, 3'b100, 3'b100, 5'd6, 1, 1, 3'(LAT_FADD), 0, 0, 1, 32'h0, 32'h0);
    drive(1'b0, 5'd0, 3'b000, 3'b000, 5'd0, 1'b0, 1'b0, 3'd0, 1'b0);
    expect_now("raw_perf", 1'b0, 1'b0, 32'h40, 32'h0, 1'b1, 2, 2);
    @(posedge clk); #1;
    idle("raw_drain1", 32'h40, 32'h0);
    idle("raw_drain2", 32'h0,  32'h0);

    // x0 and ALU forwarding, then a 1-cycle load
    cyc("x0_write",   1, 5'd0, 3'b000, 3'b000, 5'd0, 0, 1, 3'(LAT_ALU), 0, 0, 1, 32'h0, 32'h0);
    cyc("x0_read",    1, 5'd0, 3'b000, 3'b100, 5'd7, 0, 1, 3'(LAT_ALU), 0, 0, 1, 32'h0, 32'h0);
    cyc("alu_x5",     1, 5'd0, 3'b000, 3'b000, 5'd5, 0, 1, 3'(LAT_ALU), 0, 0, 1, 32'h0, 32'h0);
    cyc("alu_use_x5", 1, 5'd5, 3'b000, 3'b100, 5'd8, 0, 1, 3'(LAT_ALU), 0, 0, 1, 32'h0, 32'h0);
    cyc("x0_lat2",    1, 5'd0, 3'b000, 3'b000, 5'd0, 0, 1, 3'(LAT_FADD), 0, 0, 1, 32'h0, 32'h0);
    idle("x0_not_busy", 32'h0, 32'h0);
    cyc("load_x9",    1, 5'd0, 3'b000, 3'b000, 5'd9, 0, 1, 3'(LAT_LOAD), 0, 0, 1, 32'h0, 32'h0);
    cyc("use_x9_stl", 1, 5'd9, 3'b000, 3'b100, 5'd10, 0, 1, 3'(LAT_ALU), 0, 1, 0, 32'h0, 32'h200);
    cyc("use_x9_iss", 1, 5'd9, 3'b000, 3'b100, 5'd10, 0, 1, 3'(LAT_ALU), 0, 0, 1, 32'h0, 32'h0);

    // Result-bus collision: fmul lat 2 while fdiv f1 counter == 3
    cyc("bus_fdiv",   1, 5'd0, 3'b000, 3'b000, 5'd1, 1, 1, 3'(LAT_FDIV), 0, 0, 1, 32'h0, 32'h0);
    idle("bus_wait1", 32'h2, 32'h0);
    idle("bus_wait2", 32'h2, 32'h0);
    cyc("bus_stall",  1, 5'd0, 3'b000, 3'b000, 5'd2, 1, 1, 3'(LAT_FMUL), 0, 1, 0, 32'h2, 32'h0);
    cyc("bus_issue",  1, 5'd0, 3'b000, 3'b000, 5'd2, 1, 1, 3'(LAT_FMUL), 0, 0, 1, 32'h2, 32'h0);
    idle("bus_drain1", 32'h6, 32'h0);
    idle("bus_drain2", 32'h4, 32'h0);
    idle("bus_drain3", 32'h0, 32'h0);

    // WAW: fdiv f4 then fadd f4
    cyc("waw_fdiv",   1, 5'd0, 3'b000, 3'b000, 5'd4, 1, 1, 3'(LAT_FDIV), 0, 0, 1, 32'h0,  32'h0);
    cyc("waw_stall5", 1, 5'd0, 3'b000, 3'b000, 5'd4, 1, 1, 3'(LAT_FADD), 0, 1, 0, 32'h10, 32'h0);
    cyc("waw_stall4", 1, 5'd0, 3'b000, 3'b000, 5'd4, 1, 1, 3'(LAT_FADD), 0, 1, 0, 32'h10, 32'h0);
    cyc("waw_stall3", 1, 5'd0, 3'b000, 3'b000, 5'd4, 1, 1, 3'(LAT_FADD), 0, 1, 0, 32'h10, 32'h0);
    cyc("waw_issue",  1, 5'd0, 3'b000, 3'b000, 5'd4, 1, 1, 3'(LAT_FADD), 0, 0, 1, 32'h10, 32'h0);
    idle("waw_ld2",   32'h10, 32'h0);
    idle("waw_ld1",   32'h10, 32'h0);
    idle("waw_done",  32'h0,  32'h0);

    // Flush of a RAW-stalled fadd: no stall, no issue, no load
    cyc("fl_fmul",    1, 5'd3, 3'b000, 3'b000, 5'd3, 1, 1, 3'(LAT_FMUL), 0, 0, 1, 32'h0, 32'h0);
    cyc("fl_flush1",  1, 5'd3, 3'b100, 3'b100, 5'd6, 1, 1, 3'(LAT_FADD), 1, 0, 0, 32'h8, 32'h0);
    cyc("fl_flush2",  1, 5'd3, 3'b100, 3'b100, 5'd6, 1, 1, 3'(LAT_FADD), 1, 0, 0, 32'h8, 32'h0);
    idle("fl_noload", 32'h0, 32'h0);

    // Async reset with fp cnt[3] in flight
    cyc("rs_fdiv",    1, 5'd0, 3'b000, 3'b000, 5'd3, 1, 1, 3'(LAT_FDIV), 0, 0, 1, 32'h0, 32'h0);
    idle("rs_cnt4",   32'h8, 32'h0);
    rstn = 1'b0;
    drive(1'b1, 5'd3, 3'b100, 3'b100, 5'd9, 1'b0, 1'b1, 3'd0, 1'b0);
    expect_now("rs_in_reset", 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 0, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    drive(1'b1, 5'd3, 3'b100, 3'b100, 5'd9, 1'b0, 1'b1, 3'd0, 1'b0);
    expect_now("rs_after", 1'b0, 1'b1, 32'h0, 32'h0, 1'b1, 0, 0);
    @(posedge clk); #1;
    idle("rs_final", 32'h0, 32'h0);

    @(negedge clk); #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain queue left %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_hazard_scoreboard

`default_nettype wire
